cr_axi4s_pkt_buf: RTL and testbench

Store-and-forward AXI4-Stream frame buffer that sits directly downstream of the TLV parser top's outbound AXI4-Stream master port. It accepts beats unconditionally, holds each frame until its final beat (`tlast`) is written, and only then exposes the frame to the next stage. Frames that cannot fit in the buffer are discarded whole and counted. Downstream logic therefore never sees a partial frame and never back-pressures into the parser mid-frame.

---
 rtl/cr_axi4s_pkt_buf.sv | 136 +++++++++++++
 tb/tb_cr_axi4s_pkt_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_axi4s_pkt_buf.sv
// rtl/cr_axi4s_pkt_buf.sv - store-and-forward AXI4-Stream frame buffer with whole-frame drop
module cr_axi4s_pkt_buf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 64,
  parameter int USER_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ib_tvalid,
  output logic                      ib_tready,
  input  logic [DATA_W-1:0]         ib_tdata,
  input  logic [USER_W-1:0]         ib_tuser,
  input  logic                      ib_tlast,
  output logic                      ob_tvalid,
  input  logic                      ob_tready,
  output logic [DATA_W-1:0]         ob_tdata,
  output logic [USER_W-1:0]         ob_tuser,
  output logic                      ob_tlast,
  output logic [$clog2(DEPTH):0]    pkt_cnt,
  output logic                      drop_pulse,
  output logic [15:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + USER_W + 1;

  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DROP} state_t;

  state_t        state, state_nxt;
  ptr_t          wr_ptr, cm_ptr, rd_ptr;
  ptr_t          wr_ptr_nxt, cm_ptr_nxt;
  ptr_t          fill_lvl;
  logic [EW-1:0] mem [DEPTH];
  logic          beat, full, wr_en, commit, drop;
  logic          rd_fire, rd_last;

  // Occupancy counts speculative beats too, so a frame that outgrows the space is caught mid-frame.
  assign beat     = ib_tvalid & ib_tready;
  assign fill_lvl = wr_ptr - rd_ptr;
  assign full     = (fill_lvl == ptr_t'(DEPTH));

  assign ob_tvalid = (pkt_cnt != '0);
  assign {ob_tlast, ob_tuser, ob_tdata} = mem[rd_ptr[AW-1:0]];
  assign rd_fire   = ob_tvalid & ob_tready;
  assign rd_last   = rd_fire & ob_tlast;

  // Write FSM: append beats speculatively, publish on tlast, roll back and discard on overflow.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    cm_ptr_nxt = cm_ptr;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    if (beat) begin
      case (state)
        ST_IDLE, ST_FILL: begin
          if (!full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + ptr_t'(1);
            if (ib_tlast) begin
              cm_ptr_nxt = wr_ptr + ptr_t'(1);
              commit     = 1'b1;
              state_nxt  = ST_IDLE;
            end else begin
              state_nxt  = ST_FILL;
            end
          end else begin
            wr_ptr_nxt = cm_ptr;
            if (ib_tlast) begin
              drop      = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (ib_tlast) begin
            drop      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Beat storage; contents need no reset because pkt_cnt gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ib_tlast, ib_tuser, ib_tdata};
  end

  // Pointers, FSM state and always-ready inbound handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      ib_tready <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      cm_ptr    <= cm_ptr_nxt;
      ib_tready <= 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Committed-frame count: a commit and a final-beat read together cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + ptr_t'(1);
        2'b01:   pkt_cnt <= pkt_cnt - ptr_t'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Drop reporting: registered pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cr_axi4s_pkt_buf.sv
// tb/tb_cr_axi4s_pkt_buf.sv - self-checking bench for cr_axi4s_pkt_buf
module tb_cr_axi4s_pkt_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ib_tvalid = 1'b0;
  logic        ib_tready;
  logic [63:0] ib_tdata = '0;
  logic [1:0]  ib_tuser = '0;
  logic        ib_tlast = 1'b0;
  logic        ob_tvalid;
  logic        ob_tready = 1'b0;
  logic [63:0] ob_tdata;
  logic [1:0]  ob_tuser;
  logic        ob_tlast;
  logic [6:0]  pkt_cnt;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cr_axi4s_pkt_buf #(.DEPTH(64), .DATA_W(64), .USER_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata),
    .ib_tuser(ib_tuser), .ib_tlast(ib_tlast),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tuser(ob_tuser), .ob_tlast(ob_tlast),
    .pkt_cnt(pkt_cnt), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        vld;
    logic [63:0] data;
    logic [1:0]  user;
    logic        last;
    logic        rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic [1:0]  e_user;
    logic        e_last;
    logic [6:0]  e_pkt;
    logic        e_drop;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, return 1ns after the rising edge.
  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] u,
                       input logic l, input logic r);
    @(negedge clk);
    ib_tvalid = v; ib_tdata = d; ib_tuser = u; ib_tlast = l; ob_tready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_drop;
    int pulses;
    int seen;
    int delivered;
    logic [63:0] q[$];
    logic [63:0] e;

    vecs[0]  = '{1'b1, 64'hA5, 2'd1, 1'b1, 1'b0, 1'b1, 64'hA5, 2'd1, 1'b1, 7'd1, 1'b0};
    vecs[1]  = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[2]  = '{1'b1, 64'h11, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[3]  = '{1'b1, 64'h22, 2'd1, 1'b0, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[4]  = '{1'b1, 64'h33, 2'd2, 1'b0, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[5]  = '{1'b1, 64'h44, 2'd3, 1'b1, 1'b0, 1'b1, 64'h11, 2'd0, 1'b0, 7'd1, 1'b0};
    vecs[6]  = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd0, 1'b0, 7'd1, 1'b0};
    vecs[7]  = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b1, 64'h22, 2'd1, 1'b0, 7'd1, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b1, 64'h33, 2'd2, 1'b0, 7'd1, 1'b0};
    vecs[9]  = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b1, 64'h44, 2'd3, 1'b1, 7'd1, 1'b0};
    vecs[10] = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[11] = '{1'b1, 64'h55, 2'd2, 1'b1, 1'b0, 1'b1, 64'h55, 2'd2, 1'b1, 7'd1, 1'b0};
    vecs[12] = '{1'b1, 64'h66, 2'd1, 1'b1, 1'b1, 1'b1, 64'h66, 2'd1, 1'b1, 7'd1, 1'b0};
    vecs[13] = '{1'b1, 64'h77, 2'd0, 1'b1, 1'b0, 1'b1, 64'h66, 2'd1, 1'b1, 7'd2, 1'b0};
    vecs[14] = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b1, 64'h77, 2'd0, 1'b1, 7'd1, 1'b0};
    vecs[15] = '{1'b0, 64'h0,  2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};
    vecs[16] = '{1'b0, 64'h99, 2'd3, 1'b1, 1'b0, 1'b0, 64'h0,  2'd0, 1'b0, 7'd0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ib_tready", ib_tready, 0);
    check("rst_ob_tvalid", ob_tvalid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ib_tready", ib_tready, 1);

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].vld, vecs[i].data, vecs[i].user, vecs[i].last, vecs[i].rdy);
      check($sformatf("vec%0d_ob_tvalid", i), ob_tvalid, vecs[i].e_vld);
      check($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, vecs[i].e_pkt);
      check($sformatf("vec%0d_drop_pulse", i), drop_pulse, vecs[i].e_drop);
      if (vecs[i].e_vld) begin
        check($sformatf("vec%0d_ob_tdata", i), ob_tdata, vecs[i].e_data);
        check($sformatf("vec%0d_ob_tuser", i), ob_tuser, vecs[i].e_user);
        check($sformatf("vec%0d_ob_tlast", i), ob_tlast, vecs[i].e_last);
      end
    end
    exp_drop = 0;
    check("vec_drop_cnt", drop_cnt, 0);

    // 60-beat frame then 8-beat frame with output stalled: second frame overflows
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 64'h100 + i, 2'(i), i == 59, 1'b0);
      if (drop_pulse) pulses++;
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 64'h200 + j, 2'd0, j == 7, 1'b0);
      if (drop_pulse) pulses++;
    end
    drive(1'b0, 64'h0, 2'd0, 1'b0, 1'b0);
    if (drop_pulse) pulses++;
    exp_drop++;
    check("ovf_drop_pulses", pulses, 1);
    check("ovf_drop_cnt", drop_cnt, exp_drop);
    check("ovf_pkt_cnt", pkt_cnt, 1);
    @(negedge clk);
    ib_tvalid = 1'b0;
    ob_tready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check($sformatf("ovf_drain%0d_vld", i), ob_tvalid, 1);
      check($sformatf("ovf_drain%0d_data", i), ob_tdata, 64'h100 + i);
      check($sformatf("ovf_drain%0d_last", i), ob_tlast, i == 59);
      @(negedge clk);
    end
    check("ovf_drained_vld", ob_tvalid, 0);
    check("ovf_drained_pkt", pkt_cnt, 0);
    ob_tready = 1'b0;

    // 70-beat frame into empty buffer is always dropped
    seen = 0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 64'h700 + i, 2'd0, i == 69, 1'b0);
      if (ob_tvalid) seen++;
      if (drop_pulse) pulses++;
    end
    exp_drop++;
    check("long_never_valid", seen, 0);
    check("long_drop_pulses", pulses, 1);
    check("long_drop_cnt", drop_cnt, exp_drop);
    drive(1'b1, 64'hB1, 2'd2, 1'b0, 1'b0);
    check("post_long_b1_vld", ob_tvalid, 0);
    drive(1'b1, 64'hB2, 2'd3, 1'b1, 1'b0);
    check("post_long_vld", ob_tvalid, 1);
    check("post_long_d1", ob_tdata, 64'hB1);
    check("post_long_u1", ob_tuser, 2'd2);
    check("post_long_pkt", pkt_cnt, 1);
    drive(1'b0, 64'h0, 2'd0, 1'b0, 1'b1);
    check("post_long_d2", ob_tdata, 64'hB2);
    check("post_long_l2", ob_tlast, 1);
    drive(1'b0, 64'h0, 2'd0, 1'b0, 1'b1);
    check("post_long_empty", ob_tvalid, 0);

    // Back-to-back 1-beat frames across several pointer wraps
    delivered = 0;
    ob_tready = 1'b1;
    for (int k = 0; k < 203; k++) begin
      @(negedge clk);
      if (ob_tvalid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected_beat", ob_tdata, 64'hDEAD);
        end else begin
          e = q.pop_front();
          check("b2b_data", ob_tdata, e);
          check("b2b_last", ob_tlast, 1);
          delivered++;
        end
      end
      check("b2b_pkt_le1", pkt_cnt <= 7'd1, 1);
      if (k < 200) begin
        ib_tvalid = 1'b1; ib_tdata = 64'h4000 + k; ib_tuser = 2'(k); ib_tlast = 1'b1;
        q.push_back(64'h4000 + k);
      end else begin
        ib_tvalid = 1'b0;
      end
    end
    check("b2b_delivered", delivered, 200);
    check("b2b_queue_empty", q.size(), 0);
    check("b2b_drop_cnt", drop_cnt, exp_drop);
    ob_tready = 1'b0;

    // Fill the buffer, then saturate drop_cnt with single-beat drops
    for (int i = 0; i < 64; i++) drive(1'b1, 64'h300 + i, 2'd0, i == 63, 1'b0);
    check("sat_fill_pkt", pkt_cnt, 1);
    check("sat_fill_data", ob_tdata, 64'h300);
    for (int n = exp_drop; n < 65535; n++) drive(1'b1, 64'(n), 2'd0, 1'b1, 1'b0);
    check("sat_cnt_ffff", drop_cnt, 16'hFFFF);
    check("sat_pulse_last", drop_pulse, 1);
    drive(1'b0, 64'h0, 2'd0, 1'b0, 1'b0);
    check("sat_pulse_idle", drop_pulse, 0);
    drive(1'b1, 64'h5A5A, 2'd0, 1'b1, 1'b0);
    check("sat_pulse_extra", drop_pulse, 1);
    check("sat_cnt_held", drop_cnt, 16'hFFFF);
    check("sat_pkt_kept", pkt_cnt, 1);
    check("sat_data_kept", ob_tdata, 64'h300);

    // Reset in the middle of a frame loses everything and counts nothing
    drive(1'b1, 64'h500, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    ib_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", ob_tvalid, 0);
    check("mid_rst_pkt", pkt_cnt, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check("mid_rst_tready", ib_tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_tready", ib_tready, 1);
    drive(1'b1, 64'h600, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 64'h601, 2'd1, 1'b1, 1'b0);
    check("mid_after_vld", ob_tvalid, 1);
    check("mid_after_data", ob_tdata, 64'h600);
    check("mid_after_pkt", pkt_cnt, 1);
    check("mid_after_drops", drop_cnt, 0);
    drive(1'b0, 64'h0, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
